// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave FSM state type, used by ahb_master and ahb_sram_slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_slv_state_e;

  // Little-endian lane enables; anything wider than a halfword writes the whole word.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 4'b0001 << a;
      HSIZE_HALF: return 4'b0011 << {a[1], 1'b0};
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array: byte-lane synchronous writes, asynchronous read, no reset.
module ahb_sram_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge hclk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: address-phase capture, wait-state FSM, byte-lane writes.
// Define AHB_SLV_ERR_EN to build the address/size decode-error response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [2:0]                hburst_i,
  input  logic [3:0]                hprot_i,
  input  logic                      hmastlock_i,
  input  logic                      hready_i,
  input  logic [31:0]               hwdata_i,
  output logic                      hreadyout_o,
  output logic [31:0]               hrdata_o,
  output logic [1:0]                hresp_o
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);

  ahb_slv_state_e    state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [MEM_AW-1:0] idx_q;
  logic              write_q;
  logic [3:0]        be_q;
  logic              accept, dec_err, can_accept;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;
  logic              unused_ok;

  assign accept = hsel_i & hready_i & htrans_i[1];

`ifdef AHB_SLV_ERR_EN
  assign dec_err = (haddr_i[AHB_ADDR_WIDTH-1:MEM_AW+2] != '0)
                 | ((hsize_i == HSIZE_HALF) & haddr_i[0])
                 | ((hsize_i == HSIZE_WORD) & (haddr_i[1:0] != 2'b00))
                 | (hsize_i > HSIZE_WORD);
  assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i};
`else
  // Upper address bits alias onto the array.
  assign dec_err   = 1'b0;
  assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i, haddr_i[AHB_ADDR_WIDTH-1:MEM_AW+2]};
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept && can_accept) begin
        idx_q   <= haddr_i[MEM_AW+1:2];
        write_q <= hwrite_i;
        be_q    <= byte_en(hsize_i, haddr_i[1:0]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    can_accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: can_accept = 1'b1;
      ST_WAIT: begin
        hreadyout_o = 1'b0;
        wait_cnt_d  = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = ST_DATA;
      end
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_o    = HRESP_ERROR;
        can_accept = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Pipelined accept: a new address phase may complete in the same cycle as a data phase.
    if (can_accept) begin
      if (!accept) begin
        state_d = ST_IDLE;
`ifdef AHB_SLV_ERR_EN
      end else if (dec_err) begin
        state_d = ST_ERR1;
`endif
      end else if (WAIT_CYCLES > 0) begin
        state_d    = ST_WAIT;
        wait_cnt_d = 4'(WAIT_CYCLES);
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  assign mem_we   = (state_q == ST_DATA && write_q) ? be_q : 4'b0000;
  assign hrdata_o = (state_q == ST_DATA && !write_q) ? mem_rdata : 32'h0;

  ahb_sram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (MEM_AW)
  ) u_mem (
    .hclk  (hclk),
    .addr  (idx_q),
    .we    (mem_we),
    .wdata (hwdata_i),
    .rdata (mem_rdata)
  );

endmodule
